// File: rtl/mem_resp_ctrl_pkg.sv
// Shared types, widths and the latency selector for the memory responder.
package mem_resp_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LAT_W  = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DEPTH  = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Request-to-ack latency: fast window below fast_limit, slow elsewhere.
   function automatic logic [LAT_W-1:0] lat_sel(input logic [ADDR_W-1:0] addr,
                                                input int unsigned      fast_limit,
                                                input int unsigned      fast_lat,
                                                input int unsigned      slow_lat);
      return (32'(addr) < fast_limit) ? LAT_W'(fast_lat) : LAT_W'(slow_lat);
   endfunction

endpackage

// File: rtl/mem_resp_ctrl_if.sv
// Single-beat memory request/response bus.
//   master: drives mem_req/mem_read/mem_write/mem_addr/mem_wdata
//   slave : drives mem_ack/mem_err/mem_data plus busy/drop_cnt status
interface mem_resp_ctrl_if;
   import mem_resp_pkg::*;

   logic                mem_req;
   logic                mem_read;
   logic                mem_write;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                mem_ack;
   logic                mem_err;
   logic [DATA_W-1:0]   mem_data;
   logic                busy;
   logic [CNT_W-1:0]    drop_cnt;

   modport master (
      output mem_req, mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_ack, mem_err, mem_data, busy, drop_cnt
   );

   modport slave (
      input  mem_req, mem_read, mem_write, mem_addr, mem_wdata,
      output mem_ack, mem_err, mem_data, busy, drop_cnt
   );

endinterface

// File: rtl/mem_resp_ctrl_store.sv
// 256x32 storage array, cleared by reset, combinational read.
//   clk, rst : clock, async active-high reset
//   we       : write enable
//   addr     : word address (shared by read and write)
//   wdata    : write data
//   rdata    : combinational read data
module mem_resp_store
   import mem_resp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage array; reset clears every word so reads are never X.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem <= '{default: '0};
      end else if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_resp_ctrl.sv
// Memory-side responder: accepts single-cycle requests, acks after an
// address-dependent latency, counts requests dropped while busy.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of mem_resp_ctrl_if (request in, ack/err/data,
//              busy and drop_cnt out; all outputs registered)
module mem_resp_ctrl
   import mem_resp_pkg::*;
#(
   parameter int unsigned       FAST_LIMIT = 64,
   parameter int unsigned       FAST_LAT   = 3,
   parameter int unsigned       SLOW_LAT   = 8,
   parameter logic [ADDR_W-1:0] ERR_BASE   = 8'hF0
)(
   input  logic            clk,
   input  logic            rst,
   mem_resp_ctrl_if.slave  bus
);

   state_t             state, state_d;
   logic [LAT_W-1:0]   lat_cnt, lat_d;
   logic               rd_q, wr_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic               accept;
   logic               we;
   logic [DATA_W-1:0]  rdata;

   mem_resp_store u_store (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (rdata)
   );

   // State register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         lat_cnt <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         state   <= state_d;
         lat_cnt <= lat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
         if (accept) begin
            rd_q    <= bus.mem_read;
            wr_q    <= bus.mem_write;
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
         end
      end
   end

   // Next state, latency countdown and response/storage actions on entry to RESP.
   always_comb begin
      state_d = state;
      lat_d   = lat_cnt;
      accept  = 1'b0;
      we      = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      data_d  = data_q;
      unique case (state)
         IDLE: begin
            if (bus.mem_req) begin
               state_d = WAIT;
               accept  = 1'b1;
               lat_d   = LAT_W'(lat_sel(bus.mem_addr, FAST_LIMIT, FAST_LAT, SLOW_LAT) - LAT_W'(1));
            end
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               state_d = RESP;
               ack_d   = 1'b1;
               unique case ({rd_q, wr_q})
                  2'b10: begin
                     if (addr_q >= ERR_BASE) begin
                        err_d  = 1'b1;
                        data_d = '0;
                     end else begin
                        data_d = rdata;
                     end
                  end
                  2'b01: we = 1'b1;
                  2'b11: begin
                     err_d  = 1'b1;
                     data_d = '0;
                  end
                  default: ;
               endcase
            end else begin
               lat_d = LAT_W'(lat_cnt - LAT_W'(1));
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy_d = (state_d != IDLE);

   // Requests seen outside IDLE (including the RESP cycle) are dropped and counted.
   assign drop_d = (bus.mem_req && (state != IDLE) && (drop_q != '1))
                   ? CNT_W'(drop_q + CNT_W'(1)) : drop_q;

   assign bus.mem_ack  = ack_q;
   assign bus.mem_err  = err_q;
   assign bus.mem_data = data_q;
   assign bus.busy     = busy_q;
   assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Scoreboard bench for mem_resp_ctrl: stimulus pushes expected acks,
// a negedge monitor pops and compares them.
module tb_mem_resp_ctrl;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          ack_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];

   mem_resp_ctrl_if bus ();

   mem_resp_ctrl #(
      .FAST_LIMIT (64),
      .FAST_LAT   (3),
      .SLOW_LAT   (8),
      .ERR_BASE   (8'hF0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every ack must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (bus.mem_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack actual=ack required=none cyc=%0d", cyc);
         end else begin
            e = exp_q.pop_front();
            chk("ack_err",  32'(bus.mem_err), 32'(e.err));
            chk("ack_data", bus.mem_data, e.data);
            chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
         end
      end else if (bus.mem_err !== 1'b0) begin
         failures++;
         $display("FAIL err_without_ack actual=%b required=0", bus.mem_err);
      end
   end

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL ack_timeout actual=pending(%0d) required=0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] wd);
      bus.mem_req   = 1'b1;
      bus.mem_read  = rd;
      bus.mem_write = wr;
      bus.mem_addr  = a;
      bus.mem_wdata = wd;
   endtask

   task automatic push(input logic [7:0] a, input logic err, input logic [31:0] data);
      exp_t e;
      e.err     = err;
      e.data    = data;
      e.ack_cyc = cyc + 1 + ((a < 8'd64) ? 3 : 8);
      exp_q.push_back(e);
   endtask

   task automatic do_req(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [31:0] wd, input logic err, input logic [31:0] data);
      @(negedge clk);
      drive(rd, wr, a, wd);
      push(a, err, data);
      @(negedge clk);
      bus.mem_req = 1'b0;
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.mem_req   = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack",  32'(bus.mem_ack), 32'd0);
      chk("rst_err",  32'(bus.mem_err), 32'd0);
      chk("rst_data", bus.mem_data, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
      rst = 1'b0;

      // Basic read, write then read-back, data hold while idle.
      do_req(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 32'h0);
      do_req(1'b0, 1'b1, 8'h20, 32'hDEADBEEF, 1'b0, 32'h0);
      do_req(1'b1, 1'b0, 8'h20, 32'h0, 1'b0, 32'hDEADBEEF);
      repeat (3) @(negedge clk);
      chk("data_hold_idle", bus.mem_data, 32'hDEADBEEF);
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // Latency boundaries.
      do_req(1'b1, 1'b0, 8'h80, 32'h0, 1'b0, 32'h0);
      do_req(1'b0, 1'b1, 8'h3F, 32'h0000_003F, 1'b0, 32'h0);
      do_req(1'b1, 1'b0, 8'h3F, 32'h0, 1'b0, 32'h0000_003F);
      do_req(1'b1, 1'b0, 8'h40, 32'h0, 1'b0, 32'h0);

      // Error region, hold across write, illegal qualifiers.
      do_req(1'b0, 1'b1, 8'h05, 32'hA5A5A5A5, 1'b0, 32'h0);
      do_req(1'b1, 1'b0, 8'hF5, 32'h0, 1'b1, 32'h0);
      do_req(1'b1, 1'b0, 8'h05, 32'h0, 1'b0, 32'hA5A5A5A5);
      do_req(1'b0, 1'b1, 8'hF5, 32'h12345678, 1'b0, 32'hA5A5A5A5);
      do_req(1'b1, 1'b1, 8'h05, 32'hFFFFFFFF, 1'b1, 32'h0);
      do_req(1'b1, 1'b0, 8'h05, 32'h0, 1'b0, 32'hA5A5A5A5);
      do_req(1'b0, 1'b0, 8'h06, 32'h11111111, 1'b0, 32'hA5A5A5A5);
      do_req(1'b1, 1'b0, 8'hEF, 32'h0, 1'b0, 32'h0);

      // Requests at +1 and +2 after an accepted slow request are dropped.
      chk("drop_before", 32'(bus.drop_cnt), 32'd0);
      @(negedge clk);
      drive(1'b1, 1'b0, 8'h90, 32'h0);
      push(8'h90, 1'b0, 32'h0);
      @(negedge clk);
      chk("busy_wait", 32'(bus.busy), 32'd1);
      drive(1'b0, 1'b1, 8'h10, 32'h77777777);
      @(negedge clk);
      drive(1'b1, 1'b0, 8'h20, 32'h0);
      @(negedge clk);
      bus.mem_req = 1'b0;
      wait_done();
      chk("drop_cnt", 32'(bus.drop_cnt), 32'd2);
      repeat (12) @(negedge clk);
      do_req(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 32'h0);

      // Reset during WAIT aborts a pending write.
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h30, 32'hCAFEF00D);
      @(negedge clk);
      bus.mem_req = 1'b0;
      @(negedge clk);
      chk("busy_pre_rst", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", 32'(bus.busy), 32'd0);
      chk("rst_mid_ack",  32'(bus.mem_ack), 32'd0);
      chk("rst_mid_drop", 32'(bus.drop_cnt), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      do_req(1'b1, 1'b0, 8'h30, 32'h0, 1'b0, 32'h0);
      do_req(1'b1, 1'b0, 8'h20, 32'h0, 1'b0, 32'h0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
